quad_encoder_gen: RTL and testbench

Quadrature encoder emulator: on command, emits a programmable number of quadrature steps on A/B at a programmable rate, CW or CCW. It drives motor/encoder test stimulus and loopback of the quadrature decoding path on the board. It also tracks a running position count of every step emitted.

---
 rtl/quad_encoder_gen_if.sv | 28 ++
 rtl/quad_encoder_gen.sv | 125 ++++++++++++
 tb/tb_quad_encoder_gen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_encoder_gen_if.sv
// Command and quadrature-output bundle for the quadrature encoder emulator.
// The master side issues commands and watches A/B; the slave side is the generator.
interface quad_encoder_gen_if #(
   parameter int CNT_WIDTH = 16,
   parameter int DIV_WIDTH = 16
);
   logic                 start;
   logic [1:0]           dir;
   logic [CNT_WIDTH-1:0] steps;
   logic [DIV_WIDTH-1:0] period;
   logic                 stop;
   logic                 A;
   logic                 B;
   logic                 busy;
   logic                 done;
   logic [CNT_WIDTH-1:0] remaining;
   logic [CNT_WIDTH-1:0] position;

   modport master (
      output start, dir, steps, period, stop,
      input  A, B, busy, done, remaining, position
   );

   modport slave (
      input  start, dir, steps, period, stop,
      output A, B, busy, done, remaining, position
   );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: emits a commanded number of A/B edges at a
// programmable rate, CW or CCW, and keeps a running position count.
//
// state    | meaning
// S_IDLE   | waiting for a command; A/B hold the last phase
// S_RUN    | divider counting; one quadrature edge per terminal count
// S_FINISH | command complete or aborted; done pulses on the way out
module quad_encoder_gen #(
   parameter int CNT_WIDTH = 16,
   parameter int DIV_WIDTH = 16
) (
   input logic               clk,
   input logic               rst,
   quad_encoder_gen_if.slave enc
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

   state_t               state_q, state_d;
   logic                 cw_q, cw_d;
   logic [DIV_WIDTH-1:0] per_q, per_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [CNT_WIDTH-1:0] rem_q, rem_d;
   logic [CNT_WIDTH-1:0] pos_q, pos_d;
   logic [1:0]           ab_q, ab_d;
   logic                 done_q, done_d;

   logic                 dir_ok;
   logic [DIV_WIDTH-1:0] period_eff;

   assign dir_ok     = (enc.dir == 2'b01) || (enc.dir == 2'b10);
   assign period_eff = (enc.period == '0) ? DIV_ONE : enc.period;

   // Gray walk over {A,B}: CW 00->01->11->10, CCW the reverse.
   function automatic logic [1:0] next_ab(input logic [1:0] ab, input logic cw);
      logic [1:0] nxt;
      case (ab)
         2'b00:   nxt = cw ? 2'b01 : 2'b10;
         2'b01:   nxt = cw ? 2'b11 : 2'b00;
         2'b11:   nxt = cw ? 2'b10 : 2'b01;
         default: nxt = cw ? 2'b00 : 2'b11;
      endcase
      return nxt;
   endfunction

   always_comb begin
      state_d = state_q;
      cw_d    = cw_q;
      per_d   = per_q;
      div_d   = div_q;
      rem_d   = rem_q;
      pos_d   = pos_q;
      ab_d    = ab_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enc.start && !enc.stop) begin
               cw_d    = (enc.dir == 2'b01);
               per_d   = period_eff;
               div_d   = period_eff - DIV_ONE;
               rem_d   = enc.steps;
               state_d = ((enc.steps == '0) || !dir_ok) ? S_FINISH : S_RUN;
            end
         end
         S_RUN: begin
            // stop beats a coincident terminal count: no edge on the abort cycle
            if (enc.stop) begin
               state_d = S_FINISH;
            end else if (div_q == '0) begin
               ab_d  = next_ab(ab_q, cw_q);
               pos_d = cw_q ? (pos_q + CNT_ONE) : (pos_q - CNT_ONE);
               rem_d = rem_q - CNT_ONE;
               div_d = per_q - DIV_ONE;
               if (rem_q == CNT_ONE) begin
                  state_d = S_FINISH;
               end
            end else begin
               div_d = div_q - DIV_ONE;
            end
         end
         S_FINISH: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cw_q    <= 1'b0;
         per_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         pos_q   <= '0;
         ab_q    <= 2'b00;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cw_q    <= cw_d;
         per_q   <= per_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         pos_q   <= pos_d;
         ab_q    <= ab_d;
         done_q  <= done_d;
      end
   end

   assign enc.A         = ab_q[1];
   assign enc.B         = ab_q[0];
   assign enc.busy      = (state_q == S_RUN);
   assign enc.done      = done_q;
   assign enc.remaining = rem_q;
   assign enc.position  = pos_q;
endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: command table, hand-built corner sequences and
// randomized commands, all compared every cycle against an event-time model.
module tb_quad_encoder_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;

   quad_encoder_gen_if #(.CNT_WIDTH(16), .DIV_WIDTH(16)) enc ();

   quad_encoder_gen #(.CNT_WIDTH(16), .DIV_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .enc (enc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int edge_tot = 0;
   int done_tot = 0;
   logic [1:0] prev_ab = 2'b00;

   // Model: absolute edge times rather than a divider; phase follows position mod 4.
   int          e;
   int          m_fin;
   int          m_next;
   int          m_per;
   logic [15:0] m_pos;
   logic [15:0] m_rem;
   bit          m_busy;
   bit          m_cw;
   bit          m_done;

   typedef struct {
      logic [1:0]  dir;
      int          steps;
      int          period;
      logic [15:0] pos;
      logic [1:0]  ab;
      logic [15:0] rem;
      int          edges;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [1:0] gray_of(input logic [15:0] p);
      return {p[1], p[1] ^ p[0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      e = 0; m_fin = -10; m_next = 0; m_per = 1;
      m_pos = '0; m_rem = '0; m_busy = 0; m_cw = 0; m_done = 0;
   endtask

   task automatic model_step();
      e++;
      if (m_busy) begin
         if (enc.stop) begin
            m_busy = 0; m_fin = e;
         end else if (e == m_next) begin
            m_pos  = m_cw ? m_pos + 16'd1 : m_pos - 16'd1;
            m_rem  = m_rem - 16'd1;
            m_next = e + m_per;
            if (m_rem == 16'd0) begin
               m_busy = 0; m_fin = e;
            end
         end
      end else if (e != m_fin + 1 && enc.start && !enc.stop) begin
         m_per = (enc.period == 16'd0) ? 1 : int'(enc.period);
         m_rem = enc.steps;
         m_cw  = (enc.dir == 2'b01);
         if (enc.steps == 16'd0 || !(enc.dir == 2'b01 || enc.dir == 2'b10)) begin
            m_fin = e;
         end else begin
            m_busy = 1; m_next = e + m_per;
         end
      end
      m_done = (e == m_fin + 1);
   endtask

   task automatic tick();
      logic [63:0] act, exp;
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      act = {28'd0, enc.A, enc.B, enc.busy, enc.done, enc.remaining, enc.position};
      exp = {28'd0, gray_of(m_pos), m_busy, m_done, m_rem, m_pos};
      chk("cycle {A,B,busy,done,rem,pos}", act, exp);
      if (enc.done) done_tot++;
      if ({enc.A, enc.B} != prev_ab) edge_tot++;
      prev_ab = {enc.A, enc.B};
   endtask

   task automatic drive_cmd(input logic [1:0] d, input int st, input int pr);
      enc.start  = 1'b1;
      enc.dir    = d;
      enc.steps  = 16'(st);
      enc.period = 16'(pr);
   endtask

   // Issue a command and wait for done; stop_at>0 raises stop so it is sampled stop_at edges after accept.
   task automatic issue(input logic [1:0] d, input int st, input int pr, input int stop_at);
      bit got;
      got = 0;
      drive_cmd(d, st, pr);
      tick();
      enc.start = 1'b0;
      for (int i = 1; i < 3000 && !got; i++) begin
         if (i == stop_at) enc.stop = 1'b1;
         tick();
         enc.stop = 1'b0;
         if (enc.done) got = 1;
      end
      if (!got) chk("done timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int e0, d0;
      logic [15:0] p0;
      bit hit;

      vecs[0] = '{2'b01, 8, 4, 16'h0008, 2'b00, 16'h0000, 8};
      vecs[1] = '{2'b10, 8, 1, 16'h0000, 2'b00, 16'h0000, 8};
      vecs[2] = '{2'b10, 3, 2, 16'hFFFD, 2'b01, 16'h0000, 3};
      vecs[3] = '{2'b00, 5, 1, 16'hFFFD, 2'b01, 16'h0005, 0};
      vecs[4] = '{2'b01, 0, 3, 16'hFFFD, 2'b01, 16'h0000, 0};
      vecs[5] = '{2'b11, 5, 2, 16'hFFFD, 2'b01, 16'h0005, 0};
      vecs[6] = '{2'b01, 4, 0, 16'h0001, 2'b01, 16'h0000, 4};
      vecs[7] = '{2'b10, 2, 1, 16'hFFFF, 2'b10, 16'h0000, 2};
      vecs[8] = '{2'b01, 1, 2, 16'h0000, 2'b00, 16'h0000, 1};

      enc.start = 1'b0; enc.stop = 1'b0; enc.dir = 2'b00;
      enc.steps = '0; enc.period = '0;
      model_reset();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset outputs", {enc.A, enc.B, enc.busy, enc.done, enc.remaining, enc.position}, 64'd0);

      for (int i = 0; i < 9; i++) begin
         e0 = edge_tot; d0 = done_tot;
         issue(vecs[i].dir, vecs[i].steps, vecs[i].period, -1);
         chk("vec position", enc.position, vecs[i].pos);
         chk("vec phase", {enc.A, enc.B}, vecs[i].ab);
         chk("vec remaining", enc.remaining, vecs[i].rem);
         chk("vec edges", edge_tot - e0, vecs[i].edges);
         chk("vec done count", done_tot - d0, 1);
      end

      // Abort: stop sampled on the 4th terminal count -> 3 edges, 7 left.
      p0 = enc.position; e0 = edge_tot; d0 = done_tot;
      issue(2'b01, 10, 3, 12);
      chk("abort edges", edge_tot - e0, 3);
      chk("abort remaining", enc.remaining, 16'd7);
      chk("abort position", enc.position, p0 + 16'd3);
      chk("abort done count", done_tot - d0, 1);

      // Start re-asserted while busy is ignored.
      p0 = enc.position; e0 = edge_tot;
      drive_cmd(2'b01, 6, 2);
      tick();
      enc.start = 1'b0;
      repeat (3) tick();
      drive_cmd(2'b10, 2, 1);
      tick();
      enc.start = 1'b0;
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         tick();
         if (enc.done) hit = 1;
      end
      chk("busy start done seen", hit, 1'b1);
      chk("busy start edges", edge_tot - e0, 6);
      chk("busy start position", enc.position, p0 + 16'd6);

      // start and stop together in IDLE: nothing happens.
      e0 = edge_tot; d0 = done_tot;
      drive_cmd(2'b01, 5, 1);
      enc.stop = 1'b1;
      tick();
      enc.start = 1'b0; enc.stop = 1'b0;
      repeat (6) tick();
      chk("start+stop edges", edge_tot - e0, 0);
      chk("start+stop done", done_tot - d0, 0);

      // A command issued in the done cycle is accepted.
      p0 = enc.position; e0 = edge_tot; d0 = done_tot;
      issue(2'b01, 2, 1, -1);
      issue(2'b10, 3, 1, -1);
      chk("back-to-back edges", edge_tot - e0, 5);
      chk("back-to-back done", done_tot - d0, 2);
      chk("back-to-back position", enc.position, p0 - 16'd1);

      // Asynchronous reset after 5 edges of a running command.
      e0 = edge_tot;
      drive_cmd(2'b01, 20, 2);
      tick();
      enc.start = 1'b0;
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         tick();
         if (edge_tot - e0 >= 5) hit = 1;
      end
      chk("reset run reached 5 edges", hit, 1'b1);
      d0 = done_tot;
      rst = 1'b1;
      model_reset();
      #1;
      chk("async reset outputs", {enc.A, enc.B, enc.busy, enc.position}, 64'd0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("no done after reset", done_tot - d0, 0);
      issue(2'b01, 3, 1, -1);
      chk("post-reset position", enc.position, 16'd3);

      // Randomized commands, some aborted; the per-cycle model does the checking.
      for (int n = 0; n < 30; n++) begin
         logic [1:0] d;
         int st, pr, sa;
         d  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) :
              (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
         st = $urandom_range(0, 10);
         pr = $urandom_range(0, 4);
         sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, st * (pr == 0 ? 1 : pr) + 2) : -1;
         issue(d, st, pr, sa);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
